vram_arbiter: RTL and testbench

- Single-port VRAM sequencer for the graphics card.
- Each cycle it grants the one VRAM access to one of three sources: VGA scanout reads, buffered CPU pixel writes, or a hardware screen-fill engine.
- Scanout always wins, so the display never tears.
- It replaces the tied-off VRAM write-enable and write-data in the card top level.

---
 rtl/vram_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM sequencer: scanout reads, buffered CPU writes, screen fill
module vram_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FILL_BASE  = 0,
    parameter int FILL_COUNT = 76800
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          cpu_wr_valid,
    input  logic [ADDR_W-1:0]             cpu_wr_addr,
    input  logic [DATA_W-1:0]             cpu_wr_data,
    output logic                          cpu_wr_ready,
    input  logic                          fill_start,
    input  logic [DATA_W-1:0]             fill_value,
    output logic                          fill_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [ADDR_W-1:0]             vram_address,
    output logic                          vram_w_enable,
    output logic [DATA_W-1:0]             vram_w_data,
    input  logic [DATA_W-1:0]             vram_r_data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(FILL_BASE);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FILL_COUNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FILL} state_t;

    state_t                     state_q;
    logic [ADDR_W-1:0]          fill_cnt_q;
    logic [DATA_W-1:0]          fill_value_q;
    logic                       fill_busy_q;
    logic                       rd_valid_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]           count_q, level_d;
    logic [ADDR_W+DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ADDR_W+DATA_W-1:0]   head;

    logic fifo_empty, fifo_full, push, pop, fill_wr;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == LVL_W'(FIFO_DEPTH));
    assign cpu_wr_ready = !fifo_full && (state_q != S_DRAIN);
    assign push         = cpu_wr_valid && cpu_wr_ready;
    // Scanout owns the port whenever it asks; the fill holds the FIFO back while it runs.
    assign pop          = !rd_req && !fifo_empty && (state_q != S_FILL);
    assign fill_wr      = !rd_req && (state_q == S_FILL);
    assign level_d      = count_q + LVL_W'(push) - LVL_W'(pop);
    assign head         = mem_q[rd_ptr_q];

    assign fifo_level   = count_q;
    assign fill_busy    = fill_busy_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = vram_r_data;

    always_comb begin
        vram_address  = rd_addr;
        vram_w_data   = '0;
        vram_w_enable = 1'b0;
        if (pop) begin
            vram_address  = head[ADDR_W+DATA_W-1:DATA_W];
            vram_w_data   = head[DATA_W-1:0];
            vram_w_enable = 1'b1;
        end else if (fill_wr) begin
            vram_address  = BASE + fill_cnt_q;
            vram_w_data   = fill_value_q;
            vram_w_enable = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cpu_wr_addr, cpu_wr_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= level_d;
            rd_valid_q <= rd_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fill_cnt_q   <= '0;
            fill_value_q <= '0;
            fill_busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fill_start) begin
                        fill_value_q <= fill_value;
                        fill_cnt_q   <= '0;
                        fill_busy_q  <= 1'b1;
                        state_q      <= fifo_empty ? S_FILL : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (level_d == '0) state_q <= S_FILL;
                end
                S_FILL: begin
                    if (fill_wr) begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (fill_cnt_q == LAST) begin
                            state_q     <= S_IDLE;
                            fill_busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    fill_busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter with a queue-based reference model
module tb_vram_arbiter;
    localparam int AW = 20;
    localparam int DW = 8;
    localparam int FBASE = 'h100;
    localparam int FCOUNT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic rd_valid;
    logic cpu_wr_valid = 1'b0;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [DW-1:0] cpu_wr_data = '0;
    logic cpu_wr_ready;
    logic fill_start = 1'b0;
    logic [DW-1:0] fill_value = '0;
    logic fill_busy;
    logic [2:0] fifo_level;
    logic [AW-1:0] vram_address;
    logic vram_w_enable;
    logic [DW-1:0] vram_w_data;
    logic [DW-1:0] vram_r_data = '0;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .FILL_BASE(FBASE), .FILL_COUNT(FCOUNT)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_ready(cpu_wr_ready), .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy),
        .fifo_level(fifo_level), .vram_address(vram_address), .vram_w_enable(vram_w_enable),
        .vram_w_data(vram_w_data), .vram_r_data(vram_r_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ev_t;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    ev_t wq[$];
    ev_t rq[$];

    // Environment VRAM: registered read, written by the DUT strobes.
    logic [DW-1:0] vmem [logic [AW-1:0]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        vram_r_data <= vmem.exists(vram_address) ? vmem[vram_address] : '0;
        if (vram_w_enable) vmem[vram_address] = vram_w_data;
    end

    // Reference model state
    logic [DW-1:0] refmem [logic [AW-1:0]];
    ev_t m_fifo[$];
    int  m_state = 0;  // 0 idle, 1 drain, 2 fill
    int  m_cnt = 0;
    logic [DW-1:0] m_val = '0;
    int  exp_cyc = -1;
    logic exp_ready, exp_busy;
    int  exp_level;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return refmem.exists(a) ? refmem[a] : '0;
    endfunction

    task automatic emit(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_t e;
        e.cyc = cyc; e.a = a; e.d = d;
        wq.push_back(e);
        refmem[a] = d;
    endtask

    task automatic step(input logic rq_i, input logic [AW-1:0] ra, input logic wv, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic fs, input logic [DW-1:0] fv);
        int st;
        bit nonempty, push;
        ev_t e;
        @(posedge clk); #1;
        rd_req = rq_i; rd_addr = ra; cpu_wr_valid = wv; cpu_wr_addr = wa; cpu_wr_data = wd;
        fill_start = fs; fill_value = fv;
        st = m_state;
        exp_ready = (m_fifo.size() < 4) && (st != 1);
        exp_level = m_fifo.size();
        exp_busy  = (st != 0);
        exp_cyc   = cyc;
        push = wv && exp_ready;
        nonempty = m_fifo.size() > 0;
        if (rq_i) begin
            e.cyc = cyc + 1; e.a = ra; e.d = ref_rd(ra);
            rq.push_back(e);
        end else if (nonempty && st != 2) begin
            e = m_fifo.pop_front();
            emit(e.a, e.d);
        end else if (st == 2) begin
            emit(AW'(FBASE + m_cnt), m_val);
            m_cnt++;
            if (m_cnt == FCOUNT) m_state = 0;
        end
        if (push) begin
            e.cyc = 0; e.a = wa; e.d = wd;
            m_fifo.push_back(e);
        end
        if (st == 0 && fs) begin
            m_val = fv; m_cnt = 0;
            m_state = nonempty ? 1 : 2;
        end else if (st == 1 && m_fifo.size() == 0) begin
            m_state = 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        rd_req = 0; cpu_wr_valid = 0; fill_start = 0;
        wq.delete(); rq.delete(); m_fifo.delete();
        m_state = 0; m_cnt = 0; exp_cyc = -1;
        #1;
        chk("rst_w_enable", vram_w_enable, 0);
        chk("rst_fill_busy", fill_busy, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", cpu_wr_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: status every sampled cycle, writes and reads popped as the DUT presents them.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (exp_cyc == cyc) begin
                chk("cpu_wr_ready", cpu_wr_ready, exp_ready);
                chk("fifo_level", fifo_level, exp_level);
                chk("fill_busy", fill_busy, exp_busy);
            end
            if (vram_w_enable) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {vram_address, vram_w_data}, 0);
                end else begin
                    e = wq.pop_front();
                    chk("write_cycle", cyc, e.cyc);
                    chk("write_addr", vram_address, e.a);
                    chk("write_data", vram_w_data, e.d);
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                e = wq.pop_front();
                chk("missing_write", 0, {e.a, e.d});
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rd_valid", rd_valid, 0);
                end else begin
                    e = rq.pop_front();
                    chk("read_cycle", cyc, e.cyc);
                    chk("read_data", rd_data, e.d);
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                e = rq.pop_front();
                chk("missing_rd_valid", rd_valid, 1);
            end
        end
    end

    initial begin
        #3;
        chk("init_w_enable", vram_w_enable, 0);
        chk("init_fifo_level", fifo_level, 0);
        chk("init_fill_busy", fill_busy, 0);
        chk("init_rd_valid", rd_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Scanout reads only
        for (int i = 0; i < 3; i++) step(1, 'h10, 0, 0, 0, 0, 0);
        idle(2);

        // Fill the FIFO behind continuous reads, then let it drain
        for (int i = 0; i < 5; i++) step(1, 'h10 + i, 1, 'h200 + i, 8'h40 + 8'(i), 0, 0);
        idle(6);

        // Single push must not bypass to VRAM in its own cycle
        step(0, 0, 1, 'h123, 8'hE0, 0, 0);
        idle(2);

        // Fill without reads, then with alternate reads
        step(0, 0, 0, 0, 0, 1, 8'h1C);
        idle(10);
        step(0, 0, 0, 0, 0, 1, 8'h3A);
        for (int i = 0; i < 18; i++) step(i[0] == 1'b0, 'h100 + i, 0, 0, 0, i == 3, 8'hFF);

        // Two entries queued, fill drains them first; write during fill lands afterwards
        step(1, 'h20, 1, 'h300, 8'h11, 0, 0);
        step(1, 'h21, 1, 'h301, 8'h22, 0, 0);
        step(1, 'h22, 1, 'h302, 8'h33, 1, 8'h07);
        step(0, 0, 1, 'h303, 8'h44, 0, 0);
        step(0, 0, 1, 'h304, 8'h55, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 'h103, 8'h99, 0, 0);
        idle(12);
        step(1, 'h103, 0, 0, 0, 0, 0);
        step(1, 'h104, 0, 0, 0, 0, 0);
        idle(2);

        // Reset mid-fill with queued entries
        step(0, 0, 0, 0, 0, 1, 8'h5A);
        step(0, 0, 1, 'h400, 8'hA1, 0, 0);
        step(0, 0, 1, 'h401, 8'hA2, 0, 0);
        do_reset();
        idle(3);
        step(0, 0, 0, 0, 0, 1, 8'h6B);
        idle(12);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra, wa;
            ra = AW'($urandom_range('h0F8, 'h10F));
            wa = AW'($urandom_range('h0F8, 'h10F));
            step($urandom_range(0, 1) == 1, ra, $urandom_range(0, 2) == 0, wa, 8'($urandom),
                 $urandom_range(0, 24) == 0, 8'($urandom));
        end
        idle(40);
        @(negedge clk); #1;
        chk("writes_outstanding", wq.size(), 0);
        chk("reads_outstanding", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
